// File: rtl/am_envelope_demod.sv
// AM envelope demodulator: rectify, integrate-and-dump by DECIM, leaky DC removal,
// programmable gain and saturation to 8-bit offset-binary audio.
module am_envelope_demod #(
    parameter int DECIM      = 64,
    parameter int LOG2_DECIM = 6,
    parameter int DC_SHIFT   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_en,
    input  logic [5:0] if_filt_in,
    input  logic [1:0] gain_spi,
    output logic [7:0] audio_out,
    output logic       audio_valid,
    output logic       overflow
);
    localparam int ACC_W = 6 + LOG2_DECIM;
    localparam int DCA_W = ACC_W + DC_SHIFT;
    localparam int AC_W  = 8 + LOG2_DECIM;
    localparam int G_W   = AC_W + 3;

    localparam logic [LOG2_DECIM-1:0] CNT_LAST = LOG2_DECIM'(DECIM - 1);
    localparam logic [LOG2_DECIM-1:0] CNT_ONE  = LOG2_DECIM'(1);
    localparam logic signed [G_W-1:0] S_MAX    = G_W'(127);
    localparam logic signed [G_W-1:0] S_MIN    = G_W'(-128);

    logic [ACC_W-1:0]       acc_r;
    logic [LOG2_DECIM-1:0]  cnt_r;
    logic [ACC_W-1:0]       env_r;
    logic                   env_valid_r;
    logic [DCA_W-1:0]       dc_acc_r;
    logic [7:0]             audio_out_r;
    logic                   audio_valid_r;
    logic                   overflow_r;

    logic [5:0]             mag_s;
    logic [ACC_W-1:0]       acc_next_s;
    logic [ACC_W-1:0]       dc_s;
    logic signed [AC_W-1:0] ac_s;
    logic signed [G_W-1:0]  g_s;
    logic signed [G_W-1:0]  s_s;
    logic [DCA_W-1:0]       dc_acc_next_s;
    logic [7:0]             sat_s;
    logic                   ovf_s;

    // Full-wave rectify; unsigned 6-bit result so -32 maps to 32 without wrapping.
    always_comb begin
        mag_s = if_filt_in;
        if (if_filt_in[5]) begin
            mag_s = 6'd0 - if_filt_in;
        end else begin
            mag_s = if_filt_in;
        end
    end

    assign acc_next_s    = acc_r + {{(ACC_W-6){1'b0}}, mag_s};
    assign dc_s          = dc_acc_r[DCA_W-1:DC_SHIFT];
    assign ac_s          = $signed({{(AC_W-ACC_W){1'b0}}, env_r}) - $signed({{(AC_W-ACC_W){1'b0}}, dc_s});
    assign g_s           = $signed({{(G_W-AC_W){ac_s[AC_W-1]}}, ac_s}) <<< gain_spi;
    assign s_s           = g_s >>> (LOG2_DECIM - 2);
    assign dc_acc_next_s = dc_acc_r + {{DC_SHIFT{1'b0}}, env_r} - {{DC_SHIFT{1'b0}}, dc_s};

    // Clamp the scaled AC term to the signed 8-bit audio range and flag clipping.
    always_comb begin
        sat_s = s_s[7:0];
        ovf_s = 1'b0;
        if (s_s > S_MAX) begin
            sat_s = 8'h7F;
            ovf_s = 1'b1;
        end else if (s_s < S_MIN) begin
            sat_s = 8'h80;
            ovf_s = 1'b1;
        end else begin
            sat_s = s_s[7:0];
            ovf_s = 1'b0;
        end
    end

    // Integrate-and-dump over DECIM accepted samples; idle cycles hold acc and cnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r       <= {ACC_W{1'b0}};
            cnt_r       <= {LOG2_DECIM{1'b0}};
            env_r       <= {ACC_W{1'b0}};
            env_valid_r <= 1'b0;
        end else if (sample_en) begin
            if (cnt_r == CNT_LAST) begin
                env_r       <= acc_next_s;
                acc_r       <= {ACC_W{1'b0}};
                cnt_r       <= {LOG2_DECIM{1'b0}};
                env_valid_r <= 1'b1;
            end else begin
                acc_r       <= acc_next_s;
                cnt_r       <= cnt_r + CNT_ONE;
                env_valid_r <= 1'b0;
            end
        end else begin
            env_valid_r <= 1'b0;
        end
    end

    // DC tracking, gain and output register; runs the edge after every dump.
    always_ff @(posedge clk) begin
        if (rst) begin
            dc_acc_r      <= {DCA_W{1'b0}};
            audio_out_r   <= 8'h80;
            audio_valid_r <= 1'b0;
            overflow_r    <= 1'b0;
        end else if (env_valid_r) begin
            dc_acc_r      <= dc_acc_next_s;
            audio_out_r   <= sat_s + 8'h80;
            audio_valid_r <= 1'b1;
            overflow_r    <= overflow_r | ovf_s;
        end else begin
            audio_valid_r <= 1'b0;
        end
    end

    assign audio_out   = audio_out_r;
    assign audio_valid = audio_valid_r;
    assign overflow    = overflow_r;

endmodule
